// File: rtl/fetch_stall_controller_if.sv
// fetch_stall_controller_if: command/status bundle between Decode/Memory, the stall controller and Fetch.
interface fetch_stall_controller_if #(
   parameter int PC_WIDTH  = 16,
   parameter int CNT_WIDTH = 16
);
   logic                 I_LOCK;
   logic                 I_FRAMESTALL;
   logic                 I_DepStallSignal;
   logic                 I_BranchStallSignal;
   logic                 I_BranchAddrSelect;
   logic [PC_WIDTH-1:0]  I_BranchPC;
   logic                 O_PCWrite;
   logic                 O_PCSel;
   logic [PC_WIDTH-1:0]  O_NextPC;
   logic                 O_FetchStall;
   logic [2:0]           O_State;
   logic                 O_BranchTimeout;
   logic [CNT_WIDTH-1:0] O_StallCount;
   modport master (
      input  I_LOCK, I_FRAMESTALL, I_DepStallSignal, I_BranchStallSignal, I_BranchAddrSelect, I_BranchPC,
      output O_PCWrite, O_PCSel, O_NextPC, O_FetchStall, O_State, O_BranchTimeout, O_StallCount
   );
   modport slave (
      output I_LOCK, I_FRAMESTALL, I_DepStallSignal, I_BranchStallSignal, I_BranchAddrSelect, I_BranchPC,
      input  O_PCWrite, O_PCSel, O_NextPC, O_FetchStall, O_State, O_BranchTimeout, O_StallCount
   );
endinterface

// File: rtl/fetch_stall_controller.sv
// fetch_stall_controller: fetch sequencing FSM merging redirect, frame, branch and dependency stalls.
module fetch_stall_controller #(
   parameter int PC_WIDTH   = 16,
   parameter int BR_TIMEOUT = 8,
   parameter int CNT_WIDTH  = 16
) (
   input logic I_CLOCK,
   input logic I_RESET,
   fetch_stall_controller_if.master bus
);
   localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, DEP = 3'd2, BRWAIT = 3'd3, REDIR = 3'd4, FRAME = 3'd5;
   localparam int WW = $clog2(BR_TIMEOUT + 1);
   logic [2:0]           state_q, state_d, saved_q, saved_d;
   logic                 pcwrite_q, pcwrite_d, pcsel_q, pcsel_d, fstall_q, fstall_d;
   logic                 timeout_q, timeout_d, pend_q, pend_d;
   logic [PC_WIDTH-1:0]  npc_q, npc_d;
   logic [WW-1:0]        wait_q, wait_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   always_comb begin
      state_d   = state_q;
      saved_d   = saved_q;
      pend_d    = pend_q;
      wait_d    = wait_q;
      npc_d     = npc_q;
      timeout_d = timeout_q;
      if (!bus.I_LOCK) begin
         state_d = IDLE;
         pend_d  = 1'b0;
         wait_d  = '0;
      end else if (state_q == IDLE) begin
         state_d = RUN;
      end else if (bus.I_BranchAddrSelect) begin
         npc_d   = bus.I_BranchPC;
         wait_d  = '0;
         pend_d  = state_q == FRAME && bus.I_FRAMESTALL;
         state_d = (state_q == FRAME && bus.I_FRAMESTALL) ? FRAME : REDIR;
      end else if (state_q == FRAME) begin
         state_d = bus.I_FRAMESTALL ? FRAME : pend_q ? REDIR : saved_q;
         pend_d  = pend_q && bus.I_FRAMESTALL;
      end else if (bus.I_FRAMESTALL) begin
         // a redirect already issued resumes as plain RUN after the freeze
         state_d = FRAME;
         saved_d = (state_q == REDIR) ? RUN : state_q;
      end else if (state_q == RUN) begin
         state_d = bus.I_DepStallSignal ? DEP : bus.I_BranchStallSignal ? BRWAIT : RUN;
      end else if (state_q == DEP) begin
         state_d = bus.I_DepStallSignal ? DEP : bus.I_BranchStallSignal ? BRWAIT : RUN;
      end else if (state_q == BRWAIT) begin
         timeout_d = timeout_q || wait_q == WW'(BR_TIMEOUT - 1);
         state_d   = (wait_q == WW'(BR_TIMEOUT - 1)) ? RUN : BRWAIT;
         wait_d    = (wait_q == WW'(BR_TIMEOUT - 1)) ? '0 : wait_q + WW'(1);
      end else begin
         state_d = RUN;
      end
      pcwrite_d = state_d == RUN || state_d == REDIR;
      pcsel_d   = (state_d == FRAME) ? pcsel_q : state_d == REDIR;
      fstall_d  = (state_d == FRAME) ? fstall_q : (state_d == IDLE || state_d == BRWAIT);
      cnt_d     = (state_d inside {DEP, BRWAIT, FRAME} && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
   end
   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         state_q   <= IDLE;
         saved_q   <= RUN;
         pcwrite_q <= 1'b0;
         pcsel_q   <= 1'b0;
         fstall_q  <= 1'b1;
         timeout_q <= 1'b0;
         pend_q    <= 1'b0;
         npc_q     <= '0;
         wait_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         saved_q   <= saved_d;
         pcwrite_q <= pcwrite_d;
         pcsel_q   <= pcsel_d;
         fstall_q  <= fstall_d;
         timeout_q <= timeout_d;
         pend_q    <= pend_d;
         npc_q     <= npc_d;
         wait_q    <= wait_d;
         cnt_q     <= cnt_d;
      end
   end
   assign bus.O_PCWrite       = pcwrite_q;
   assign bus.O_PCSel         = pcsel_q;
   assign bus.O_NextPC        = npc_q;
   assign bus.O_FetchStall    = fstall_q;
   assign bus.O_State         = state_q;
   assign bus.O_BranchTimeout = timeout_q;
   assign bus.O_StallCount    = cnt_q;
endmodule
